// File: rtl/nd_count_update_if.sv
// nd_count_update_if: request handshake and nd_topic memory port of the count updater.
interface nd_count_update_if #(
    parameter int WORDSIZE  = 32,
    parameter int ADDRSIZE  = 32,
    parameter int TOPICBITS = 8
);
    localparam int DOCBITS = ADDRSIZE - TOPICBITS;
    logic                 i_valid;
    logic                 o_ready;
    logic [DOCBITS-1:0]   i_doc;
    logic [TOPICBITS-1:0] i_old_topic;
    logic [TOPICBITS-1:0] i_new_topic;
    logic                 i_init;
    logic                 o_done;
    logic                 o_err;
    logic                 o_mem_wen;
    logic [ADDRSIZE-1:0]  o_mem_addr;
    logic [WORDSIZE-1:0]  o_mem_wdata;
    logic [WORDSIZE-1:0]  i_mem_rdata;
    modport master (
        output i_valid, i_doc, i_old_topic, i_new_topic, i_init, i_mem_rdata,
        input  o_ready, o_done, o_err, o_mem_wen, o_mem_addr, o_mem_wdata
    );
    modport slave (
        input  i_valid, i_doc, i_old_topic, i_new_topic, i_init, i_mem_rdata,
        output o_ready, o_done, o_err, o_mem_wen, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/nd_count_update.sv
// nd_count_update: moves one document's count from old topic to new topic with saturating read-modify-write.
module nd_count_update #(
    parameter int WORDSIZE  = 32,
    parameter int ADDRSIZE  = 32,
    parameter int TOPICBITS = 8
) (
    input logic clk,
    input logic rst,
    nd_count_update_if.slave bus
);
    localparam int DOCBITS = ADDRSIZE - TOPICBITS;
    typedef enum logic [2:0] {IDLE, RD_OLD, WR_OLD, RD_NEW, WR_NEW, DONE} state_t;
    state_t               state, next;
    logic [DOCBITS-1:0]   doc;
    logic [TOPICBITS-1:0] old_t, new_t;
    logic                 err;
    logic                 sat;
    // Saturation is judged on the read data that the current write stage consumes.
    assign sat = (state == WR_OLD && bus.i_mem_rdata == '0) || (state == WR_NEW && &bus.i_mem_rdata);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            doc   <= '0;
            old_t <= '0;
            new_t <= '0;
            err   <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && bus.i_valid) begin
                doc   <= bus.i_doc;
                old_t <= bus.i_old_topic;
                new_t <= bus.i_new_topic;
                err   <= 1'b0;
            end else if (sat) begin
                err <= 1'b1;
            end
        end
    end
    always_comb begin
        next = IDLE;
        unique case (state)
            IDLE:    next = !bus.i_valid ? IDLE : bus.i_init ? RD_NEW :
                            (bus.i_old_topic == bus.i_new_topic) ? DONE : RD_OLD;
            RD_OLD:  next = WR_OLD;
            WR_OLD:  next = RD_NEW;
            RD_NEW:  next = WR_NEW;
            WR_NEW:  next = DONE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        bus.o_ready     = state == IDLE;
        bus.o_mem_wen   = state == WR_OLD || state == WR_NEW;
        bus.o_mem_addr  = {doc, (state == RD_OLD || state == WR_OLD) ? old_t : new_t};
        bus.o_mem_wdata = state == WR_OLD ? (bus.i_mem_rdata == '0 ? '0 : bus.i_mem_rdata - WORDSIZE'(1)) :
                          state == WR_NEW ? (&bus.i_mem_rdata ? bus.i_mem_rdata : bus.i_mem_rdata + WORDSIZE'(1)) :
                          '0;
        bus.o_done      = state == DONE;
        bus.o_err       = state == DONE && err;
    end
endmodule
